// File: rtl/regfile_pkg.sv
// Shared definitions for the parametrised dual-read register file:
// clear-sequencer state encoding and the address-width helper.
package regfile_pkg;

    typedef enum logic {
        RF_IDLE  = 1'b0,
        RF_CLEAR = 1'b1
    } rf_state_t;

    // Never narrower than one bit, so a degenerate DEPTH still yields legal ports.
    function automatic int rf_addr_width(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One asynchronous read port: busy and out-of-range zeroing, optional
// write-through bypass, and a tri-state output controlled by i_en.
module regfile_read_port #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 4,
    parameter int AW     = 2,
    parameter bit BYPASS = 1'b1
) (
    input  logic             i_en,
    input  logic [AW-1:0]    i_addr,
    input  logic             i_busy,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic [WIDTH-1:0] i_mem_word,
    output logic [WIDTH-1:0] o_data
);

    logic             w_in_range;
    logic             w_hit;
    logic [WIDTH-1:0] w_value;

    assign w_in_range = (32'(i_addr) < 32'(DEPTH));
    assign w_hit      = BYPASS && i_wr_en && (i_wr_addr == i_addr);

    always_comb begin
        w_value = i_mem_word;
        if (i_busy || !w_in_range) begin
            w_value = '0;
        end else if (w_hit) begin
            w_value = i_wr_data;
        end
    end

    assign o_data = i_en ? w_value : 'z;

endmodule

// File: rtl/param_register_file.sv
// WIDTH x DEPTH register file, one clocked write port, two combinational
// read ports (L/R), with a post-reset clear sequencer that reports busy.
module param_register_file
    import regfile_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int DEPTH          = 4,
    parameter int AW             = rf_addr_width(DEPTH),
    parameter bit BYPASS         = 1'b1,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rdL_en,
    input  logic [AW-1:0]    rdL_addr,
    output logic [WIDTH-1:0] rdL_data,
    input  logic             rdR_en,
    input  logic [AW-1:0]    rdR_addr,
    output logic [WIDTH-1:0] rdR_data,
    output logic             busy
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    rf_state_t        r_state;
    logic [AW-1:0]    r_clr_ptr;
    logic             r_busy;
    logic             w_wr_commit;

    assign w_wr_commit = wr_en && !r_busy && (32'(wr_addr) < 32'(DEPTH));
    assign busy        = r_busy;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_clr_ptr <= '0;
            if (CLEAR_ON_RESET) begin
                r_state <= RF_CLEAR;
                r_busy  <= 1'b1;
            end else begin
                r_state <= RF_IDLE;
                r_busy  <= 1'b0;
            end
        end else begin
            case (r_state)
                RF_CLEAR: begin
                    if (32'(r_clr_ptr) == 32'(DEPTH - 1)) begin
                        r_state <= RF_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_clr_ptr <= r_clr_ptr + AW'(1);
                    end
                end
                default: begin
                    r_state <= RF_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // The clear pointer owns the write path for the whole sequence, so
    // external writes cannot race the zeroing.
    always_ff @(posedge clk) begin
        if (r_state == RF_CLEAR) begin
            r_mem[r_clr_ptr] <= '0;
        end else if (w_wr_commit) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    regfile_read_port #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW),
        .BYPASS(BYPASS)
    ) u_rd_l (
        .i_en      (rdL_en),
        .i_addr    (rdL_addr),
        .i_busy    (r_busy),
        .i_wr_en   (wr_en),
        .i_wr_addr (wr_addr),
        .i_wr_data (wr_data),
        .i_mem_word(r_mem[rdL_addr]),
        .o_data    (rdL_data)
    );

    regfile_read_port #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW),
        .BYPASS(BYPASS)
    ) u_rd_r (
        .i_en      (rdR_en),
        .i_addr    (rdR_addr),
        .i_busy    (r_busy),
        .i_wr_en   (wr_en),
        .i_wr_addr (wr_addr),
        .i_wr_data (wr_data),
        .i_mem_word(r_mem[rdR_addr]),
        .o_data    (rdR_data)
    );

endmodule

// File: tb/tb_param_register_file.sv
// Scoreboard bench: instance 0 uses defaults (8x4, bypass), instance 1 is
// 16x6 without bypass; a reference model queues expected reads per cycle.
module tb_param_register_file;

    typedef struct {
        bit          chk;
        bit          busy;
        bit          zl;
        bit          zr;
        logic [15:0] l;
        logic [15:0] r;
        string       tag;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        wr_en   [2];
    logic [2:0]  wr_addr [2];
    logic [15:0] wr_data [2];
    logic        l_en    [2];
    logic        r_en    [2];
    logic [2:0]  l_addr  [2];
    logic [2:0]  r_addr  [2];

    wire  [7:0]  a_l_data;
    wire  [7:0]  a_r_data;
    logic        a_busy;
    wire  [15:0] b_l_data;
    wire  [15:0] b_r_data;
    logic        b_busy;

    int          depth_c [2] = '{4, 6};
    bit          bypass_c[2] = '{1'b1, 1'b0};
    logic [15:0] mask_c  [2] = '{16'h00FF, 16'hFFFF};

    logic [15:0] mdl_mem [2][8];
    int          mdl_clear_left [2];
    bit          mdl_known [2];

    exp_t q0[$];
    exp_t q1[$];

    int checks = 0;
    int errors = 0;

    param_register_file u_dut_a (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en[0]),
        .wr_addr (wr_addr[0][1:0]),
        .wr_data (wr_data[0][7:0]),
        .rdL_en  (l_en[0]),
        .rdL_addr(l_addr[0][1:0]),
        .rdL_data(a_l_data),
        .rdR_en  (r_en[0]),
        .rdR_addr(r_addr[0][1:0]),
        .rdR_data(a_r_data),
        .busy    (a_busy)
    );

    param_register_file #(
        .WIDTH (16),
        .DEPTH (6),
        .BYPASS(1'b0)
    ) u_dut_b (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en[1]),
        .wr_addr (wr_addr[1]),
        .wr_data (wr_data[1]),
        .rdL_en  (l_en[1]),
        .rdL_addr(l_addr[1]),
        .rdL_data(b_l_data),
        .rdR_en  (r_en[1]),
        .rdR_addr(r_addr[1]),
        .rdR_data(b_r_data),
        .busy    (b_busy)
    );

    // Starting high puts a sampling negedge ahead of every active edge.
    initial clk = 1'b1;
    always #5 clk = ~clk;

    function automatic logic [15:0] ref_read(input int i, input logic [2:0] addr);
        if (mdl_clear_left[i] > 0) return 16'h0000;
        if (int'(addr) >= depth_c[i]) return 16'h0000;
        if (bypass_c[i] && wr_en[i] && (wr_addr[i] == addr)) return wr_data[i] & mask_c[i];
        return mdl_mem[i][addr];
    endfunction

    task automatic step(input string tag);
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            e.chk  = mdl_known[i];
            e.busy = (mdl_clear_left[i] > 0);
            e.zl   = !l_en[i];
            e.zr   = !r_en[i];
            e.l    = ref_read(i, l_addr[i]);
            e.r    = ref_read(i, r_addr[i]);
            e.tag  = tag;
            if (i == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                mdl_known[i]      = 1'b1;
                mdl_clear_left[i] = depth_c[i];
                for (int a = 0; a < 8; a++) mdl_mem[i][a] = 16'h0000;
            end else if (mdl_clear_left[i] > 0) begin
                mdl_clear_left[i]--;
            end else if (wr_en[i] && (int'(wr_addr[i]) < depth_c[i])) begin
                mdl_mem[i][wr_addr[i]] = wr_data[i] & mask_c[i];
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        for (int i = 0; i < 2; i++) begin
            wr_en[i]   = 1'b0;
            wr_addr[i] = 3'd0;
            wr_data[i] = 16'h0000;
            l_en[i]    = 1'b1;
            r_en[i]    = 1'b1;
            l_addr[i]  = 3'd0;
            r_addr[i]  = 3'd0;
        end
    endtask

    function automatic void cmp_rd(input string nm, input string tag, input int i,
                                   input logic [15:0] act, input bit z, input logic [15:0] exp);
        logic [15:0] zv;
        bit ok;
        zv = (i == 0) ? 16'h00zz : 16'hzzzz;
        checks++;
        // A released bus reads as Z in 4-state tools and as 0 in 2-state ones.
        if (z) ok = (act === zv) || (act === 16'h0000);
        else   ok = (act === exp);
        if (!ok) begin
            errors++;
            if (z) $display("FAIL %s inst%0d %s: got %h, required hi-Z", nm, i, tag, act);
            else   $display("FAIL %s inst%0d %s: got %h, required %h", nm, i, tag, act, exp);
        end
    endfunction

    function automatic void check_entry(input int i, input exp_t e, input logic bsy,
                                        input logic [15:0] l, input logic [15:0] r);
        $display("[%0t] inst%0d %s busy=%b L=%h R=%h", $time, i, e.tag, bsy, l, r);
        if (!e.chk) return;
        checks++;
        if (bsy !== e.busy) begin
            errors++;
            $display("FAIL busy inst%0d %s: got %b, required %b", i, e.tag, bsy, e.busy);
        end
        cmp_rd("rdL", e.tag, i, l, e.zl, e.l);
        cmp_rd("rdR", e.tag, i, r, e.zr, e.r);
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q0.size() > 0) begin
                e = q0.pop_front();
                check_entry(0, e, a_busy, {8'h00, a_l_data}, {8'h00, a_r_data});
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                check_entry(1, e, b_busy, b_l_data, b_r_data);
            end
        end
    end

    initial begin : stimulus
        mdl_known      = '{1'b0, 1'b0};
        mdl_clear_left = '{0, 0};
        idle_inputs();
        reset = 1'b1;
        step("reset");
        reset = 1'b0;

        // Write during busy must be dropped; watch busy length on both instances.
        wr_en[0] = 1'b1; wr_addr[0] = 3'd1; wr_data[0] = 16'h00AA;
        step("wr_during_busy");
        wr_en[0] = 1'b0;
        for (int k = 0; k < 6; k++) begin
            l_addr[1] = 3'(k); r_addr[1] = 3'(k);
            step("busy_window");
        end
        for (int k = 0; k < 4; k++) begin
            l_addr[0] = 3'(k); r_addr[0] = 3'(k);
            step("cleared_read");
        end

        // Directed writes and simultaneous reads.
        wr_en[0] = 1'b1; wr_addr[0] = 3'd0; wr_data[0] = 16'h005A; step("wr_5A");
        wr_addr[0] = 3'd3; wr_data[0] = 16'h00C3;                  step("wr_C3");
        wr_en[0] = 1'b0; l_addr[0] = 3'd0; r_addr[0] = 3'd3;        step("rd_0_3");
        l_addr[0] = 3'd3;                                           step("rd_3_3");

        // Bypass on instance 0, no bypass on instance 1.
        for (int i = 0; i < 2; i++) begin
            wr_en[i] = 1'b1; wr_addr[i] = 3'd2; wr_data[i] = 16'h0011;
        end
        step("wr_11");
        for (int i = 0; i < 2; i++) begin
            wr_data[i] = 16'h0077; l_addr[i] = 3'd2;
        end
        step("wr_77_rd2");
        wr_en[0] = 1'b0; wr_en[1] = 1'b0;
        step("rd2_after");

        // Right port released while left still reads.
        l_addr[0] = 3'd0; r_addr[0] = 3'd3; r_en[0] = 1'b0; step("rdR_off");
        r_en[0] = 1'b1;                                     step("rdR_on");

        // Out-of-range handling on the 6-deep instance.
        wr_en[1] = 1'b1; wr_addr[1] = 3'd7; wr_data[1] = 16'hBEEF; step("wr_addr7");
        wr_addr[1] = 3'd5; wr_data[1] = 16'h1234;                  step("wr_addr5");
        wr_en[1] = 1'b0; l_addr[1] = 3'd6; r_addr[1] = 3'd7;       step("rd_6_7");
        l_addr[1] = 3'd5;                                           step("rd_5_7");

        // Randomised traffic with occasional resets.
        for (int n = 0; n < 300; n++) begin
            reset = ($urandom_range(0, 59) == 0);
            for (int i = 0; i < 2; i++) begin
                wr_en[i]   = $urandom_range(0, 1) == 1;
                wr_addr[i] = 3'($urandom_range(0, (i == 0) ? 3 : 7));
                wr_data[i] = 16'($urandom) & mask_c[i];
                l_en[i]    = $urandom_range(0, 7) != 0;
                r_en[i]    = $urandom_range(0, 7) != 0;
                l_addr[i]  = 3'($urandom_range(0, (i == 0) ? 3 : 7));
                r_addr[i]  = 3'($urandom_range(0, (i == 0) ? 3 : 7));
            end
            step("random");
        end

        // Held reset, then reset re-asserted with the clear pointer at 2.
        idle_inputs();
        reset = 1'b1;
        for (int k = 0; k < 3; k++) step("reset_held");
        reset = 1'b0;
        step("clear_p0");
        step("clear_p1");
        reset = 1'b1;
        step("reset_midclear");
        reset = 1'b0;
        for (int k = 0; k < 7; k++) begin
            for (int i = 0; i < 2; i++) begin
                wr_en[i]   = 1'b1;
                wr_addr[i] = 3'(k % 4);
                wr_data[i] = 16'hFFFF & mask_c[i];
                l_addr[i]  = 3'(k % 4);
            end
            step("restart_clear");
        end
        idle_inputs();
        for (int k = 0; k < 4; k++) begin
            l_addr[0] = 3'(k); r_addr[0] = 3'(3 - k);
            l_addr[1] = 3'(k); r_addr[1] = 3'(k + 2);
            step("final_read");
        end

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
